// File: rtl/frame_stim_ctrl.sv
// Frame/line timing stimulus generator: emits fval/lval framing with a ramp pixel pattern
// for a programmable number of frames, plus an enable window for a downstream data checker.
module frame_stim_ctrl #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned CHANNEL_NUM = 4,
    parameter int unsigned FVAL_LEAD   = 2,
    parameter int unsigned LINE_ACTIVE = 16,
    parameter int unsigned LINE_BLANK  = 4,
    parameter int unsigned LINE_NUM    = 8,
    parameter int unsigned FVAL_TAIL   = 2,
    parameter int unsigned FRAME_BLANK = 10
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              i_start,
    input  logic                              i_stop,
    input  logic [15:0]                       iv_frame_num,
    output logic                              o_fval,
    output logic                              o_lval,
    output logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
    output logic                              o_chk_en,
    output logic                              o_busy,
    output logic                              o_done,
    output logic [15:0]                       ov_frame_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StLead,
        StActive,
        StLblank,
        StTail,
        StFblank
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] line_q, line_d;
    logic [31:0] pix_q, pix_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] frame_num_q, frame_num_d;
    logic        stop_q, stop_d;
    logic        stop_eff;

    logic                              fval_q, fval_d;
    logic                              lval_q, lval_d;
    logic [DATA_WIDTH*CHANNEL_NUM-1:0] pix_data_q, pix_data_d;
    logic                              busy_q, busy_d;
    logic                              done_q, done_d;

    assign stop_eff = stop_q | i_stop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            line_q      <= '0;
            pix_q       <= '0;
            frame_cnt_q <= '0;
            frame_num_q <= '0;
            stop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_q      <= line_d;
            pix_q       <= pix_d;
            frame_cnt_q <= frame_cnt_d;
            frame_num_q <= frame_num_d;
            stop_q      <= stop_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 32'd1;
        line_d      = line_q;
        pix_d       = pix_q;
        frame_cnt_d = frame_cnt_q;
        frame_num_d = frame_num_q;
        stop_d      = stop_eff;
        case (state_q)
            StIdle: begin
                cnt_d  = '0;
                stop_d = 1'b0;
                if (i_start) begin
                    state_d     = StLead;
                    frame_cnt_d = '0;
                    frame_num_d = iv_frame_num;
                    line_d      = '0;
                    pix_d       = '0;
                end
            end
            StLead: begin
                if (cnt_q == FVAL_LEAD - 1) begin
                    state_d = StActive;
                    cnt_d   = '0;
                end
            end
            StActive: begin
                if (cnt_q == LINE_ACTIVE - 1) begin
                    cnt_d = '0;
                    if (line_q == LINE_NUM - 1) begin
                        state_d = StTail;
                    end else begin
                        state_d = StLblank;
                        line_d  = line_q + 32'd1;
                    end
                end
            end
            StLblank: begin
                if (cnt_q == LINE_BLANK - 1) begin
                    state_d = StActive;
                    cnt_d   = '0;
                end
            end
            StTail: begin
                if (cnt_q == FVAL_TAIL - 1) begin
                    state_d     = StFblank;
                    cnt_d       = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            StFblank: begin
                if (cnt_q == FRAME_BLANK - 1) begin
                    cnt_d = '0;
                    if (!stop_eff && (frame_num_q == '0 || frame_cnt_q < frame_num_q)) begin
                        state_d = StLead;
                        line_d  = '0;
                        pix_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // pix_q counts active cycles already emitted, so it advances with each one scheduled
        if (state_d == StActive) begin
            pix_d = pix_q + 32'd1;
        end
    end

    // Outputs are computed from the next state so they line up with state_q after the edge.
    always_comb begin
        fval_d     = (state_d == StLead) || (state_d == StActive) ||
                     (state_d == StLblank) || (state_d == StTail);
        lval_d     = (state_d == StActive);
        busy_d     = (state_d != StIdle);
        done_d     = (state_q != StIdle) && (state_d == StIdle);
        pix_data_d = '0;
        if (state_d == StActive) begin
            for (int n = 0; n < CHANNEL_NUM; n++) begin
                pix_data_d[n*DATA_WIDTH +: DATA_WIDTH] =
                    DATA_WIDTH'(pix_q * CHANNEL_NUM + 32'(n));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fval_q     <= 1'b0;
            lval_q     <= 1'b0;
            pix_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            fval_q     <= fval_d;
            lval_q     <= lval_d;
            pix_data_q <= pix_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_fval       = fval_q;
    assign o_lval       = lval_q;
    assign ov_pix_data  = pix_data_q;
    assign o_busy       = busy_q;
    assign o_chk_en     = busy_q;
    assign o_done       = done_q;
    assign ov_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_frame_stim_ctrl.sv
// Bench for frame_stim_ctrl: randomized start/stop/frame-count stimulus compared every cycle
// against a frame-position model built from the timing arithmetic.
module tb_frame_stim_ctrl;

    localparam int DW   = 8;
    localparam int CN   = 4;
    localparam int LEAD = 2;
    localparam int LA   = 16;
    localparam int LB   = 4;
    localparam int LN   = 8;
    localparam int TAIL = 2;
    localparam int FB   = 10;
    localparam int LP   = LA + LB;
    localparam int F    = LEAD + LN * LA + (LN - 1) * LB + TAIL;
    localparam int P    = F + FB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_start = 1'b0;
    logic          i_stop = 1'b0;
    logic [15:0]   iv_frame_num = '0;
    logic          o_fval, o_lval, o_chk_en, o_busy, o_done;
    logic [31:0]   ov_pix_data;
    logic [15:0]   ov_frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // model: position within the current frame period and run bookkeeping
    bit          m_run = 1'b0;
    bit          m_stop = 1'b0;
    bit          m_done = 1'b0;
    int          m_t = 0;
    logic [15:0] m_cnt = '0;
    logic [15:0] m_num = '0;

    int fval_run = 0;
    int lval_run = 0;

    frame_stim_ctrl #(
        .DATA_WIDTH  (DW),
        .CHANNEL_NUM (CN),
        .FVAL_LEAD   (LEAD),
        .LINE_ACTIVE (LA),
        .LINE_BLANK  (LB),
        .LINE_NUM    (LN),
        .FVAL_TAIL   (TAIL),
        .FRAME_BLANK (FB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .iv_frame_num (iv_frame_num),
        .o_fval       (o_fval),
        .o_lval       (o_lval),
        .ov_pix_data  (ov_pix_data),
        .o_chk_en     (o_chk_en),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .ov_frame_cnt (ov_frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit exp_lval(input int t);
        int u;
        u = t - LEAD;
        if (t < LEAD || u >= LN * LP - LB) return 1'b0;
        return (u % LP) < LA;
    endfunction

    function automatic logic [31:0] exp_pix(input int t);
        logic [31:0] v;
        int u, k;
        v = '0;
        if (exp_lval(t)) begin
            u = t - LEAD;
            k = (u / LP) * LA + u % LP;
            for (int n = 0; n < CN; n++) v[n*DW +: DW] = 8'((k * CN + n) % 256);
        end
        return v;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run  <= 1'b0;
            m_stop <= 1'b0;
            m_done <= 1'b0;
            m_t    <= 0;
            m_cnt  <= '0;
            m_num  <= '0;
        end else begin
            m_done <= 1'b0;
            if (!m_run) begin
                if (i_start) begin
                    m_run  <= 1'b1;
                    m_t    <= 0;
                    m_cnt  <= '0;
                    m_num  <= iv_frame_num;
                    m_stop <= 1'b0;
                end
            end else begin
                if (i_stop) m_stop <= 1'b1;
                if (m_t == P - 1) begin
                    if (!(m_stop || i_stop) && (m_num == 0 || m_cnt < m_num)) begin
                        m_t <= 0;
                    end else begin
                        m_run  <= 1'b0;
                        m_done <= 1'b1;
                    end
                end else begin
                    m_t <= m_t + 1;
                    if (m_t + 1 == F) m_cnt <= m_cnt + 16'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check_eq("fval", 32'(o_fval), 32'(m_run && m_t < F));
        check_eq("lval", 32'(o_lval), 32'(m_run && exp_lval(m_t)));
        check_eq("pix", ov_pix_data, m_run ? exp_pix(m_t) : 32'h0);
        check_eq("chk_en", 32'(o_chk_en), 32'(m_run));
        check_eq("busy", 32'(o_busy), 32'(m_run));
        check_eq("done", 32'(o_done), 32'(m_done));
        check_eq("frame_cnt", 32'(ov_frame_cnt), 32'(m_cnt));
        if (reset) begin
            fval_run <= 0;
            lval_run <= 0;
        end else begin
            if (o_fval) begin
                fval_run <= fval_run + 1;
            end else begin
                if (fval_run != 0) check_eq("fval_len", 32'(fval_run), 32'(F));
                fval_run <= 0;
            end
            if (o_lval) begin
                lval_run <= lval_run + 1;
            end else begin
                if (lval_run != 0) check_eq("lval_len", 32'(lval_run), 32'(LA));
                lval_run <= 0;
            end
        end
    end

    task automatic pulse(input bit s, input bit p, input logic [15:0] num);
        @(posedge clk);
        #1;
        i_start      = s;
        i_stop       = p;
        iv_frame_num = num;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_stop  = 1'b0;
    endtask

    // Waits for o_done; optionally throws ignored start pulses at the busy DUT.
    task automatic wait_done(input int budget, input bit rnd_start);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(posedge clk);
            #1;
            i_start = 1'b0;
            if (o_done) seen = 1'b1;
            else if (rnd_start && m_run && m_t < P - 20 && $urandom_range(0, 39) == 0)
                i_start = 1'b1;
        end
        i_start = 1'b0;
        check_eq("done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        int d;
        logic [15:0] num;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_fval", 32'(o_fval), 32'd0);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_pix", ov_pix_data, 32'd0);
        reset = 1'b0;

        // two-frame run with ignored starts while busy
        pulse(1'b1, 1'b0, 16'd2);
        wait_done(3 * P, 1'b1);
        check_eq("a_frames", 32'(ov_frame_cnt), 32'd2);
        check_eq("a_chk_en", 32'(o_chk_en), 32'd0);
        pulse(1'b0, 1'b1, 16'd0);
        repeat (4) @(posedge clk);
        #1;
        check_eq("idle_stop_busy", 32'(o_busy), 32'd0);
        check_eq("idle_hold_cnt", 32'(ov_frame_cnt), 32'd2);

        // continuous run stopped in line 3 of frame 5
        pulse(1'b1, 1'b0, 16'd0);
        repeat (4 * P + 45) @(posedge clk);
        #1;
        i_stop = 1'b1;
        @(posedge clk);
        #1;
        i_stop = 1'b0;
        wait_done(2 * P, 1'b0);
        check_eq("b_frames", 32'(ov_frame_cnt), 32'd5);
        check_eq("b_chk_en_done", 32'(o_chk_en), 32'd0);

        // async reset during the first active line
        pulse(1'b1, 1'b0, 16'd3);
        repeat (8) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_eq("ar_fval", 32'(o_fval), 32'd0);
        check_eq("ar_lval", 32'(o_lval), 32'd0);
        check_eq("ar_pix", ov_pix_data, 32'd0);
        check_eq("ar_chk_en", 32'(o_chk_en), 32'd0);
        check_eq("ar_busy", 32'(o_busy), 32'd0);
        check_eq("ar_done", 32'(o_done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // start and stop together in idle: start wins
        num = 16'($urandom_range(1, 2));
        pulse(1'b1, 1'b1, num);
        check_eq("ss_busy", 32'(o_busy), 32'd1);
        wait_done(3 * P, 1'b1);
        check_eq("ss_frames", 32'(ov_frame_cnt), 32'(num));

        for (int r = 0; r < 3; r++) begin
            num = 16'($urandom_range(1, 3));
            pulse(1'b1, 1'b0, num);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom_range(1, P - 2);
                repeat (d) @(posedge clk);
                #1;
                i_stop = 1'b1;
                @(posedge clk);
                #1;
                i_stop = 1'b0;
                num = 16'd1;
            end
            wait_done(4 * P, 1'b1);
            check_eq("rnd_frames", 32'(ov_frame_cnt), 32'(num));
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
